muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 124 ++++++++++++
 tb/tb_muldiv_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RISC-V M-extension multiply/divide unit, one bit per cycle
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready  operand handshake; in_ready is high only while IDLE
//   op                  funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   a, b                rs1 / rs2 operands, sampled only on the accept edge
//   flush               synchronous abort of the in-flight or held operation
//   out_valid, out_ready, result   result handshake; result held until taken
//   zero                result == 0
//   busy                iterating (BUSY) or applying the sign fixup (FIXUP)
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] most_neg = {1'b1, {(WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, BUSY, FIXUP, DONE} state_t;
  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic               neg_q, neg_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   bop_q, bop_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf, fast;
  logic [WIDTH-1:0]   a_mag, b_mag, rem_base, div_val;
  logic [WIDTH:0]     mul_sum, rem_sh, rem_diff;
  logic [2*WIDTH-1:0] prod_fix;
  always_comb begin
    a_sgn    = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    b_sgn    = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    a_neg    = a_sgn && a[WIDTH-1];
    b_neg    = b_sgn && b[WIDTH-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    div_zero = op[2] && (b == '0);
    div_ovf  = op[2] && !op[0] && (a == most_neg) && (b == '1);
    fast     = div_zero || div_ovf;
    // Multiply: product register holds {partial high, remaining multiplier bits}.
    mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, bop_q} : '0);
    // Divide: rem_q keeps the raw difference including its borrow bit; a borrowed
    // step is restored at the start of the next step (and in FIXUP) by adding the
    // divisor back. The restored value is always below the divisor, so WIDTH bits suffice.
    rem_base = rem_q[WIDTH-1:0] + (rem_q[WIDTH] ? bop_q : '0);
    rem_sh   = {rem_base, prod_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, bop_q};
    prod_fix = neg_q ? -prod_q : prod_q;
    div_val  = op_q[1] ? rem_base : prod_q[WIDTH-1:0];
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    bop_d    = bop_q;
    result_d = result_q;
    case (state_q)
      IDLE: if (in_valid && !flush) begin
        op_d     = op;
        neg_d    = (op == 3'd6) ? a_neg : a_neg ^ b_neg;
        cnt_d    = CW'(WIDTH - 1);
        prod_d   = {{WIDTH{1'b0}}, a_mag};
        rem_d    = '0;
        bop_d    = b_mag;
        state_d  = fast ? DONE : BUSY;
        result_d = !fast ? result_q : div_zero ? (op[1] ? a : '1) : (op[1] ? '0 : a);
      end
      BUSY: begin
        cnt_d   = cnt_q - CW'(1);
        rem_d   = op_q[2] ? rem_diff : rem_q;
        prod_d  = op_q[2] ? {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-2:0], ~rem_diff[WIDTH]}
                          : {mul_sum, prod_q[WIDTH-1:1]};
        state_d = (cnt_q == '0) ? FIXUP : BUSY;
      end
      FIXUP: begin
        result_d = op_q[2] ? (neg_q ? -div_val : div_val)
                 : (op_q[1:0] == 2'd0) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
        state_d  = DONE;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      bop_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      bop_q    <= bop_d;
      result_q <= result_d;
    end
  end
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == BUSY) || (state_q == FIXUP);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = (result_q == '0);
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit at WIDTH=32 and WIDTH=8
module tb_muldiv_unit;
  typedef struct {
    logic [31:0] res;
    int          acc;
    int          lat;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1, sel = 1'b0;
  logic [2:0] op = '0;
  logic [31:0] a = '0, b = '0;
  logic ir32, ov32, z32, bz32, ir8, ov8, z8, bz8;
  logic [31:0] r32;
  logic [7:0] r8;
  logic in_ready, out_valid, zero, busy;
  logic [31:0] result;
  exp_t sbq[$];
  int cyc = 0, n_cmp = 0, n_bad = 0;
  bit hold = 1'b0, rnd_bp = 1'b0, prev_ov = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  muldiv_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~sel), .in_ready(ir32), .op(op), .a(a), .b(b),
    .flush(flush), .out_valid(ov32), .out_ready(out_ready & ~sel), .result(r32), .zero(z32), .busy(bz32));
  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & sel), .in_ready(ir8), .op(op), .a(a[7:0]), .b(b[7:0]),
    .flush(flush), .out_valid(ov8), .out_ready(out_ready & sel), .result(r8), .zero(z8), .busy(bz8));
  assign in_ready  = sel ? ir8 : ir32;
  assign out_valid = sel ? ov8 : ov32;
  assign zero      = sel ? z8 : z32;
  assign busy      = sel ? bz8 : bz32;
  assign result    = sel ? {24'h0, r8} : r32;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic bad(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask
  function automatic logic [31:0] wmask(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
  endfunction
  function automatic logic signed [63:0] sx(input logic [31:0] v, input int w);
    logic signed [63:0] t;
    t = {v, 32'h0} << (32 - w);
    return t >>> (64 - w);
  endfunction
  // Reference: wide signed/unsigned arithmetic straight from the M-extension definitions.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input int w);
    logic signed [63:0] sa, sb, ua, ub, p;
    sa = sx(x, w);
    sb = sx(y, w);
    ua = {32'h0, x};
    ub = {32'h0, y};
    case (o)
      3'd0: p = sa * sb;
      3'd1: p = (sa * sb) >>> w;
      3'd2: p = (sa * ub) >>> w;
      3'd3: p = (ua * ub) >> w;
      3'd4: if (y == 0) p = -1; else p = sa / sb;
      3'd5: if (y == 0) p = -1; else p = ua / ub;
      3'd6: if (y == 0) p = sa; else p = sa % sb;
      default: if (y == 0) p = ua; else p = ua % ub;
    endcase
    return p[31:0] & wmask(w);
  endfunction
  function automatic bit is_fast(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input int w);
    return o[2] && (y == 0 || (!o[0] && x == (32'h1 << (w - 1)) && y == wmask(w)));
  endfunction
  function automatic logic [31:0] pick(input int w);
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return wmask(w);
      3: return 32'h1 << (w - 1);
      default: return $urandom & wmask(w);
    endcase
  endfunction
  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit track, input bit use_lit, input logic [31:0] lit);
    int w, t;
    exp_t e;
    w = sel ? 8 : 32;
    x &= wmask(w);
    y &= wmask(w);
    t = 0;
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      bad("accept timeout");
      return;
    end
    op = o;
    a = x;
    b = y;
    in_valid = 1'b1;
    if (track) begin
      e.res = use_lit ? lit : model(o, x, y, w);
      e.acc = cyc + 1;
      e.lat = is_fast(o, x, y, w) ? 0 : w + 1;
      sbq.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
    op = 3'($urandom);
    a = $urandom;
    b = $urandom;
  endtask
  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (sbq.size() != 0) begin
      bad("drain timeout");
      sbq.delete();
    end
  endtask
  always @(negedge clk) begin
    out_ready = hold ? 1'b0 : rnd_bp ? 1'($urandom_range(0, 1)) : 1'b1;
    if (out_valid) begin
      if (sbq.size() == 0) bad("spurious out_valid");
      else begin
        if (!prev_ov) chk("latency", 64'(cyc - sbq[0].acc), 64'(sbq[0].lat));
        if (out_ready) begin
          chk("result", result, sbq[0].res);
          chk("zero", zero, sbq[0].res == 0);
          void'(sbq.pop_front());
        end
      end
    end
    prev_ov = out_valid;
  end
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  logic [2:0]  d_op[12]  = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd7, 3'd4, 3'd6};
  logic [31:0] d_a[12]   = '{32'h7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                             32'hFFFFFFFE, 32'h7, 32'h5, 32'h5, 32'h80000000, 32'h80000000};
  logic [31:0] d_b[12]   = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'h2, 32'h2, 32'h2,
                             32'h2, 32'h7, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] d_exp[12] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
                             32'h7FFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h5, 32'h80000000, 32'h0};
  initial begin
    logic [31:0] rv;
    logic zv;
    int t;
    repeat (3) @(negedge clk);
    chk("reset out_valid", out_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset result", result, 0);
    chk("reset zero", zero, 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset in_ready", in_ready, 1);
    for (int i = 0; i < 12; i++) begin
      issue(d_op[i], d_a[i], d_b[i], 1'b1, 1'b1, d_exp[i]);
      if (i >= 8) chk("fast busy", busy, 0);
      drain();
    end
    hold = 1'b1;
    issue(3'd0, 32'd3, 32'd5, 1'b1, 1'b1, 32'd15);
    t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) bad("backpressure out_valid timeout");
    rv = result;
    zv = zero;
    for (int i = 0; i < 10; i++) begin
      chk("bp out_valid", out_valid, 1);
      chk("bp result", result, rv);
      chk("bp zero", zero, zv);
      chk("bp in_ready", in_ready, 0);
      in_valid = 1'b1;
      op = 3'd4;
      a = $urandom;
      b = $urandom | 32'h1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    hold = 1'b0;
    drain();
    @(negedge clk);
    chk("bp post in_ready", in_ready, 1);
    chk("bp post busy", busy, 0);
    issue(3'd4, 32'd1000, 32'd3, 1'b0, 1'b0, 32'd0);
    repeat (10) @(negedge clk);
    chk("flush pre busy", busy, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush in_ready", in_ready, 1);
    chk("flush busy", busy, 0);
    chk("flush out_valid", out_valid, 0);
    repeat (40) @(negedge clk);
    issue(3'd5, 32'd100, 32'd7, 1'b1, 1'b1, 32'd14);
    drain();
    @(negedge clk);
    flush = 1'b1;
    in_valid = 1'b1;
    op = 3'd0;
    a = 32'd3;
    b = 32'd3;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush-wins busy", busy, 0);
    chk("flush-wins in_ready", in_ready, 1);
    chk("flush-wins result", result, 14);
    issue(3'd3, $urandom, $urandom, 1'b0, 1'b0, 32'd0);
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", out_valid, 0);
    chk("async rst busy", busy, 0);
    chk("async rst result", result, 0);
    chk("async rst zero", zero, 1);
    chk("async rst in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(3'd6, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b1, 32'hFFFFFFFF);
    drain();
    rnd_bp = 1'b1;
    for (int i = 0; i < 250; i++) issue(3'($urandom_range(0, 7)), pick(32), pick(32), 1'b1, 1'b0, 32'd0);
    drain();
    @(negedge clk);
    @(negedge clk);
    sel = 1'b1;
    @(negedge clk);
    issue(3'd4, 32'h80, 32'hFF, 1'b1, 1'b1, 32'h80);
    issue(3'd6, 32'h80, 32'hFF, 1'b1, 1'b1, 32'h0);
    for (int i = 0; i < 250; i++) issue(3'($urandom_range(0, 7)), pick(8), pick(8), 1'b1, 1'b0, 32'd0);
    drain();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
